// File: rtl/byte_download_pkg.sv
// Shared types and sizing helpers for the byte download source.
package byte_download_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;

  // Occupancy must be able to represent DEPTH itself, hence one extra bit.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned LEVEL_W_DEF = level_width(DEPTH_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StWaitRelease
  } state_e;

endpackage

// File: rtl/byte_download_source_if.sv
// PIO link between the byte source (master) and the Nios side (slave).
interface byte_download_source_if #(
  parameter int unsigned DATA_W = 8
);
  logic [1:0]        outsignal_export;
  logic              readytodownload1_export;
  logic [DATA_W-1:0] curbyte1_export;
  logic              readytodownload2_export;
  logic [DATA_W-1:0] curbyte2_export;

  modport master (
    input  outsignal_export,
    output readytodownload1_export,
    output curbyte1_export,
    output readytodownload2_export,
    output curbyte2_export
  );

  modport slave (
    output outsignal_export,
    input  readytodownload1_export,
    input  curbyte1_export,
    input  readytodownload2_export,
    input  curbyte2_export
  );
endinterface

// File: rtl/byte_download_channel.sv
// One download channel: FIFO, registered acknowledge, 4-phase handshake FSM and sent counter.
module byte_download_channel
  import byte_download_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned LEVEL_W = level_width(DEPTH),
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               ack,
  output logic               readytodownload,
  output logic [DATA_W-1:0]  curbyte,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   sent
);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [LEVEL_W-1:0] level_q;
  state_e             state_q;
  logic               ack_q;
  logic               rdy_q;
  logic [DATA_W-1:0]  cur_q;
  logic [CNT_W-1:0]   sent_q;
  logic               push, pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign wr_ready = (level_q != LEVEL_W'(DEPTH));
  assign push     = wr_valid & wr_ready;
  assign pop      = (state_q == StIdle) && (level_q != '0) && !ack_q;

  // Storage array; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wr_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Handshake FSM with registered outputs; every decision uses the registered acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cur_q   <= '0;
      sent_q  <= '0;
    end else begin
      ack_q <= ack;
      case (state_q)
        StIdle: begin
          if (pop) begin
            cur_q   <= mem[rptr_q];
            rdy_q   <= 1'b1;
            state_q <= StPresent;
          end
        end
        StPresent: begin
          if (ack_q) begin
            rdy_q   <= 1'b0;
            sent_q  <= sent_q + CNT_W'(1);
            state_q <= StWaitRelease;
          end
        end
        StWaitRelease: begin
          if (!ack_q) state_q <= StIdle;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign readytodownload = rdy_q;
  assign curbyte         = cur_q;
  assign level           = level_q;
  assign sent            = sent_q;

endmodule

// File: rtl/byte_download_source.sv
// Dual-channel byte producer driving the Nios PIO download inputs.
module byte_download_source
  import byte_download_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned LEVEL_W = level_width(DEPTH)
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [DATA_W-1:0]      wr_data1,
  input  logic                   wr_valid1,
  output logic                   wr_ready1,
  input  logic [DATA_W-1:0]      wr_data2,
  input  logic                   wr_valid2,
  output logic                   wr_ready2,
  byte_download_source_if.master pio,
  output logic [LEVEL_W-1:0]     level1,
  output logic [LEVEL_W-1:0]     level2,
  output logic [CNT_W-1:0]       sent1,
  output logic [CNT_W-1:0]       sent2
);

  byte_download_channel #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_ch1 (
    .clk             (clk_clk),
    .rst             (reset_reset),
    .wr_data         (wr_data1),
    .wr_valid        (wr_valid1),
    .wr_ready        (wr_ready1),
    .ack             (pio.outsignal_export[0]),
    .readytodownload (pio.readytodownload1_export),
    .curbyte         (pio.curbyte1_export),
    .level           (level1),
    .sent            (sent1)
  );

  byte_download_channel #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_ch2 (
    .clk             (clk_clk),
    .rst             (reset_reset),
    .wr_data         (wr_data2),
    .wr_valid        (wr_valid2),
    .wr_ready        (wr_ready2),
    .ack             (pio.outsignal_export[1]),
    .readytodownload (pio.readytodownload2_export),
    .curbyte         (pio.curbyte2_export),
    .level           (level2),
    .sent            (sent2)
  );

endmodule

// File: tb/tb_byte_download_source.sv
// Directed bench for byte_download_source with a per-channel byte scoreboard.
module tb_byte_download_source;
  import byte_download_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = LEVEL_W_DEF;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wr_data1, wr_data2;
  logic          wr_valid1, wr_valid2;
  logic          wr_ready1, wr_ready2;
  logic [LW-1:0] level1, level2;
  logic [CW-1:0] sent1, sent2;

  byte_download_source_if #(.DATA_W(DW)) pio ();

  byte_download_source #(
    .DEPTH  (DEPTH_DEF),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (reset),
    .wr_data1    (wr_data1),
    .wr_valid1   (wr_valid1),
    .wr_ready1   (wr_ready1),
    .wr_data2    (wr_data2),
    .wr_valid2   (wr_valid2),
    .wr_ready2   (wr_ready2),
    .pio         (pio),
    .level1      (level1),
    .level2      (level2),
    .sent1       (sent1),
    .sent2       (sent2)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  int          sent_m[2];

  function logic [31:0] rdy(input int ch);
    return (ch == 0) ? 32'(pio.readytodownload1_export) : 32'(pio.readytodownload2_export);
  endfunction
  function logic [31:0] cur(input int ch);
    return (ch == 0) ? 32'(pio.curbyte1_export) : 32'(pio.curbyte2_export);
  endfunction
  function logic [31:0] lvl(input int ch);
    return (ch == 0) ? 32'(level1) : 32'(level2);
  endfunction
  function logic [31:0] snt(input int ch);
    return (ch == 0) ? 32'(sent1) : 32'(sent2);
  endfunction
  function logic [31:0] wrr(input int ch);
    return (ch == 0) ? 32'(wr_ready1) : 32'(wr_ready2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q1.delete();
    q2.delete();
    sent_m[0] = 0;
    sent_m[1] = 0;
  endtask

  // Push one byte, waiting (bounded) for space; the byte joins the scoreboard.
  task automatic push(input int ch, input logic [7:0] b);
    int n = 0;
    if (ch == 0) begin wr_data1 = b; wr_valid1 = 1'b1; end
    else         begin wr_data2 = b; wr_valid2 = 1'b1; end
    while (wrr(ch) != 1 && n < 50) begin tick(); n++; end
    chk("push_ready", wrr(ch), 1);
    tick();
    if (ch == 0) begin wr_valid1 = 1'b0; q1.push_back(b); end
    else         begin wr_valid2 = 1'b0; q2.push_back(b); end
  endtask

  // Full 4-phase handshake on one channel, with exact acknowledge-response timing.
  task automatic handshake(input int ch, input int hold);
    int n = 0;
    logic [7:0] e = 8'h00;
    while (rdy(ch) != 1 && n < 50) begin tick(); n++; end
    chk("ready_up", rdy(ch), 1);
    if (ch == 0) begin if (q1.size() > 0) e = q1.pop_front(); end
    else         begin if (q2.size() > 0) e = q2.pop_front(); end
    chk("curbyte", cur(ch), 32'(e));
    pio.outsignal_export[ch] = 1'b1;
    tick();
    chk("ready_hold", rdy(ch), 1);
    chk("curbyte_stable", cur(ch), 32'(e));
    tick();
    chk("ready_fall", rdy(ch), 0);
    sent_m[ch]++;
    chk("sent", snt(ch), 32'(sent_m[ch] % 16));
    repeat (hold) tick();
    chk("ack_once", snt(ch), 32'(sent_m[ch] % 16));
    chk("wait_release", rdy(ch), 0);
    pio.outsignal_export[ch] = 1'b0;
    tick();
  endtask

  initial begin
    int pushed;
    int n;
    logic [7:0] e1, e2;
    reset = 1'b1;
    wr_data1 = '0; wr_data2 = '0;
    wr_valid1 = 1'b0; wr_valid2 = 1'b0;
    pio.outsignal_export = 2'b00;
    tick();
    tick();
    do_reset();

    // Reset state on both channels
    for (int c = 0; c < 2; c++) begin
      chk("rst_ready", rdy(c), 0);
      chk("rst_curbyte", cur(c), 0);
      chk("rst_level", lvl(c), 0);
      chk("rst_sent", snt(c), 0);
      chk("rst_wr_ready", wrr(c), 1);
    end

    // First byte latency: push at t, presented after t+1
    push(0, 8'hA5);
    tick();
    chk("first_ready1", rdy(0), 1);
    chk("first_curbyte1", cur(0), 'hA5);
    chk("idle_ready2", rdy(1), 0);
    chk("idle_curbyte2", cur(1), 0);
    push(0, 8'h3C);
    handshake(0, 0);
    handshake(0, 3);

    // Fill to DEPTH with one byte presented, then drain 40 bytes through a pointer wrap
    for (int i = 0; i < 17; i++) push(0, 8'(64 + i));
    pushed = 17;
    chk("full_level1", lvl(0), 16);
    chk("full_wr_ready1", wrr(0), 0);
    chk("full_ready1", rdy(0), 1);
    wr_data1 = 8'hEE;
    wr_valid1 = 1'b1;
    repeat (3) tick();
    chk("held_level1", lvl(0), 16);
    chk("held_wr_ready1", wrr(0), 0);
    wr_valid1 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      handshake(0, k % 3);
      if (pushed < 40) begin
        push(0, 8'(64 + pushed));
        pushed++;
      end
    end
    repeat (5) tick();
    chk("drained_level1", lvl(0), 0);
    chk("empty_no_ready1", rdy(0), 0);

    // Stale acknowledge held through reset blocks presentation until released
    pio.outsignal_export[1] = 1'b1;
    do_reset();
    push(1, 8'h11);
    repeat (4) tick();
    chk("stale_ready2", rdy(1), 0);
    chk("stale_level2", lvl(1), 1);
    pio.outsignal_export[1] = 1'b0;
    tick();
    chk("release_ready2_early", rdy(1), 0);
    tick();
    chk("release_ready2", rdy(1), 1);
    chk("release_curbyte2", cur(1), 'h11);
    handshake(1, 0);

    // Concurrency: simultaneous acknowledge, then random interleaving
    for (int i = 0; i < 8; i++) begin
      push(0, 8'($urandom_range(0, 255)));
      push(1, 8'($urandom_range(0, 255)));
    end
    repeat (3) tick();
    chk("both_ready1", rdy(0), 1);
    chk("both_ready2", rdy(1), 1);
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    chk("both_cur1", cur(0), 32'(e1));
    chk("both_cur2", cur(1), 32'(e2));
    pio.outsignal_export = 2'b11;
    tick();
    tick();
    chk("both_fall1", rdy(0), 0);
    chk("both_fall2", rdy(1), 0);
    sent_m[0]++;
    sent_m[1]++;
    pio.outsignal_export = 2'b00;
    tick();
    n = 0;
    while ((q1.size() + q2.size()) > 0 && n < 40) begin
      int ch = int'($urandom_range(0, 1));
      if (ch == 0 && q1.size() == 0) ch = 1;
      if (ch == 1 && q2.size() == 0) ch = 0;
      handshake(ch, int'($urandom_range(0, 3)));
      n++;
    end
    chk("conc_sent1", snt(0), 32'(sent_m[0] % 16));
    chk("conc_sent2", snt(1), 32'(sent_m[1] % 16));

    // Counter wrap with CNT_W=4: 17 handshakes leave sent=1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push(1, 8'(128 + i));
      handshake(1, 0);
    end
    chk("wrap_sent2", snt(1), 1);

    // Reset mid-transfer discards the presented and buffered bytes
    do_reset();
    for (int i = 0; i < 7; i++) push(0, 8'(200 + i));
    handshake(0, 0);
    n = 0;
    while (rdy(0) != 1 && n < 20) begin tick(); n++; end
    chk("pre_rst_ready1", rdy(0), 1);
    chk("pre_rst_level1", lvl(0), 5);
    chk("pre_rst_sent1", snt(0), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ready1", rdy(0), 0);
    chk("mid_rst_level1", lvl(0), 0);
    chk("mid_rst_sent1", snt(0), 0);
    chk("mid_rst_curbyte1", cur(0), 0);
    reset = 1'b0;
    q1.delete();
    sent_m[0] = 0;
    tick();
    chk("post_rst_wr_ready1", wrr(0), 1);
    repeat (3) tick();
    chk("post_rst_no_ready1", rdy(0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
